// File: rtl/data_mem_wb.sv
// Memory-access / write-back stage: word RAM with a one-cycle load stall,
// plus memory-mapped I/O (LED register, cycle counter, store counter).
//
// Ports:
//   Clock      rising-edge clock
//   Reset      asynchronous, active-high reset
//   ALU_result effective address, or pass-through value for non-loads
//   Out2       store data
//   MemWrite   store request
//   MemtoReg   load request, selects memory data for write-back
//   DataToWd   write-back data to the register file
//   Stall      hold PC and suppress RegWrite while high
//   Misalign   sticky misaligned-access flag
//   LED        I/O LED register
module data_mem_wb #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Out2,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  output logic [31:0] DataToWd,
  output logic        Stall,
  output logic        Misalign,
  output logic [15:0] LED
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                r_state;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic [31:0]           r_cyc;
  logic [31:0]           r_stc;
  logic [15:0]           r_led;
  logic                  r_mis;

  logic                  w_io;
  logic                  w_bad;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]            w_off;
  logic                  w_ld;
  logic                  w_st;
  logic                  w_st_ram;
  logic                  w_st_led;
  logic                  w_st_cyc;
  logic [31:0]           w_io_rd;

  assign w_io  = (ALU_result[31:8] == IO_BASE[31:8]);
  assign w_bad = (ALU_result[1:0] != 2'b00) & (MemWrite | MemtoReg);
  assign w_idx = ALU_result[ADDR_WIDTH+1:2];
  assign w_off = ALU_result[7:0];

  // RAM load starts only from IDLE; the CPU re-presents it in RD_WAIT.
  assign w_ld = (r_state == IDLE) & MemtoReg & ~MemWrite
              & ~w_io & ~w_bad;

  // MemWrite wins over MemtoReg when both are asserted.
  assign w_st     = (r_state == IDLE) & MemWrite & ~w_bad;
  assign w_st_ram = w_st & ~w_io;
  assign w_st_led = w_st & w_io & (w_off == 8'h00);
  assign w_st_cyc = w_st & w_io & (w_off == 8'h04);

  assign Stall    = w_ld & ~Reset;
  assign Misalign = r_mis;
  assign LED      = r_led;

  always_comb begin
    w_io_rd = 32'h0;
    case (w_off)
      8'h00:   w_io_rd = {16'h0, r_led};
      8'h04:   w_io_rd = r_cyc;
      8'h08:   w_io_rd = r_stc;
      default: w_io_rd = 32'h0;
    endcase
  end

  always_comb begin
    DataToWd = ALU_result;
    if (w_bad)
      DataToWd = 32'h0;
    else if (r_state == RD_WAIT)
      DataToWd = r_rdata;
    else if (MemtoReg & ~MemWrite & w_io)
      DataToWd = w_io_rd;
  end

  // RAM contents and read register are intentionally not reset.
  always_ff @(posedge Clock) begin
    if (w_st_ram)
      r_mem[w_idx] <= Out2;
    if (w_ld)
      r_rdata <= r_mem[w_idx];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cyc   <= 32'h0;
      r_stc   <= 32'h0;
      r_led   <= 16'h0;
      r_mis   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE:    r_state <= w_ld ? RD_WAIT : IDLE;
        RD_WAIT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_bad)
        r_mis <= 1'b1;
      if (w_st_led)
        r_led <= Out2[15:0];
      // A software write takes precedence over the free-running increment.
      if (w_st_cyc)
        r_cyc <= Out2;
      else
        r_cyc <= r_cyc + 32'h1;
      if (w_st)
        r_stc <= r_stc + 32'h1;
    end
  end

endmodule

// File: doc/data_mem_wb.md
Name: data_mem_wb

Overview:
- Memory-access and write-back stage placed directly downstream of the CPU datapath.
- Consumes the ALU result (address), store data, MemWrite and MemtoReg.
- Produces DataToWd, the value written back to the register file.
- Holds a synchronous word RAM (1-cycle read latency, hence a load-stall FSM) plus a small memory-mapped I/O block: LED register, cycle counter, store counter.

Parameters:
- ADDR_WIDTH, 8: RAM word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- IO_BASE, 32'hFFFF_FF00: base of the I/O window. Window = addresses whose [31:8] equals IO_BASE[31:8].

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ALU_result  input  32  effective address for loads/stores; pass-through value for non-loads.
- Out2  input  32  store data.
- MemWrite  input  1  store request.
- MemtoReg  input  1  load request; selects memory data for write-back.
- DataToWd  output  32  write-back data to the register file.
- Stall  output  1  CPU must hold PC and suppress RegWrite while high.
- Misalign  output  1  sticky flag: a misaligned access was attempted.
- LED  output  16  I/O LED register.

Behaviour:
- Reset (async, active-high) forces:
  - FSM to IDLE; Stall=0 (combinationally, while Reset=1).
  - LED=0, cycle counter=0, store counter=0, Misalign=0.
  - RAM contents are not reset.
- Decode:
  - io = (ALU_result[31:8]==IO_BASE[31:8]).
  - RAM index = ALU_result[ADDR_WIDTH+1:2]; upper bits above the index are ignored (aliasing).
  - bad = (ALU_result[1:0]!=0) & (MemWrite|MemtoReg).
- Misaligned access:
  - No RAM or I/O write, no stall, DataToWd=0.
  - Misalign sets at the next edge and stays set until Reset.
- Illegal MemWrite & MemtoReg together:
  - Treated as a store only.
  - DataToWd=ALU_result; no stall.
- FSM states IDLE, RD_WAIT:
  - IDLE & MemtoReg & !MemWrite & !io & !bad: RAM read issued at this edge; Stall=1 this cycle; next state RD_WAIT.
  - RD_WAIT: Stall=0; DataToWd = RAM read data; next state IDLE unconditionally. The CPU still presents the same load during RD_WAIT.
  - All other cases stay in IDLE with Stall=0.
  - Back-to-back loads therefore cost 2 cycles each.
- DataToWd when not a RAM load:
  - MemtoReg with io: combinational I/O read, no stall.
  - Otherwise: ALU_result.
- I/O read map (offset = ALU_result[7:0]):
  - 0x00: {16'b0, LED}
  - 0x04: cycle counter
  - 0x08: store counter
  - any other offset: 0
- Stores take effect at the rising edge when MemWrite & !bad & state==IDLE:
  - RAM store: RAM[index] <= Out2.
  - I/O offset 0x00: LED <= Out2[15:0].
  - I/O offset 0x04: cycle counter <= Out2. The write overrides that cycle's increment.
  - Other I/O offsets: ignored.
  - Store counter increments on every performed store (RAM or I/O); wraps at 2^32.
- Cycle counter: +1 every clock when not written; wraps 32'hFFFF_FFFF to 0.
- Reset during RD_WAIT: load abandoned; FSM returns to IDLE; no write-back.
- RAM access: single-port, synchronous read/write, read-before-write irrelevant because a load and a store never occur in the same cycle.

Test Plan:
- Reset with Clock running, then release → LED=0, Stall=0, Misalign=0. Read 0x...FF04 after 5 edges → 5 (±1 per the read edge).
- Store Out2=32'hDEADBEEF to addr 0x10, then load 0x10 → Stall=1 for exactly 1 cycle; RD_WAIT cycle DataToWd=32'hDEADBEEF; store counter reads 1.
- Store Out2=32'h0001_A5A5 to 32'hFFFF_FF00 → LED=16'hA5A5 after the edge. Load 32'hFFFF_FF00 → DataToWd=32'h0000_A5A5 with no stall.
- Store to addr 0x13 → RAM word 4 unchanged, Misalign=1 and stays 1 across later good accesses. Load 0x22 → DataToWd=0, no stall.
- Store 32'hFFFF_FFFE to 32'hFFFF_FF04, run 3 cycles → counter reads 32'h0000_0001 (wrap).
- Non-memory op with ALU_result=32'h1234 → DataToWd=32'h1234, Stall=0.
- Assert Reset in RD_WAIT → Stall=0 immediately, FSM IDLE.
- Two back-to-back loads → two 2-cycle sequences with correct data.
